rv32_mem_responder: RTL and testbench
=====================================

Name: rv32_mem_responder

Overview:
Memory-side responder for the RV32 core's instruction and data ports. It serves instruction fetches and data loads/stores from one word-organised storage array. Read latency is fixed and parameterised. After reset it clears itself, then serves requests, and it flags illegal accesses. It sits between the RV32 core and the testbench/top level, replacing ad-hoc bench memories.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored (power of two, 16..65536)
READ_LATENCY, 1, clock cycles from address sample to read data on both read ports (1..4)
NOP_WORD, 32'h0000_0013, instruction returned for illegal fetches (ADDI x0,x0,0)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous active-low reset
instr_addr_i  in  32  byte address of instruction fetch, sampled every cycle
instr_data_o  out  32  fetched instruction, READ_LATENCY cycles after address
mem_we_i  in  1  active-high data write strobe
mem_addr_i  in  32  byte address for data load/store
mem_data_i  in  32  store data
mem_data_o  out  32  load data, READ_LATENCY cycles after address
busy_o  out  1  high while the post-reset clear is in progress
err_o  out  1  sticky illegal-access flag
err_addr_o  out  32  byte address of the first illegal access since reset

Behaviour:
- Reset (rst_i low, asynchronous): all read pipeline stages are 0, instr_data_o=0, mem_data_o=0, busy_o=1, err_o=0, err_addr_o=0, FSM=CLEAR, clear pointer=0. Array contents are not touched during reset.
- FSM CLEAR:
  - Each cycle, write 0 to word[ptr] and increment ptr.
  - When ptr reaches DEPTH_WORDS-1 and that word is written, go to SERVE.
  - CLEAR lasts exactly DEPTH_WORDS cycles after reset deassertion.
  - busy_o drops in the first SERVE cycle.
- In CLEAR: mem_we_i is ignored, the read pipelines are fed 0, and no errors are recorded.
- FSM SERVE: stays in SERVE until the next reset. Reset mid-CLEAR or mid-SERVE restarts CLEAR from ptr=0.
- Address decode, per port:
  - word index = addr[log2(DEPTH_WORDS)+1:2].
  - Legal access: addr[1:0]==0 and addr < 4*DEPTH_WORDS.
- Reads (SERVE):
  - Both ports are sampled every cycle, with no handshake.
  - Data passes through READ_LATENCY register stages. The stage-1 value is the array word, NOP_WORD (illegal instr access) or 0 (illegal data access).
  - Back-to-back addresses give one result per cycle.
- Writes (SERVE):
  - mem_we_i=1 with a legal mem_addr_i writes mem_data_i at that clock edge.
  - Illegal writes are dropped.
- Read-during-write, same word, same cycle (either port): the read returns the old contents. The new value is visible to a read sampled on the next cycle.
- Errors:
  - Any illegal access in SERVE sets err_o=1 on the next edge. This covers an instr fetch, a data read, or a data write.
  - err_o is sticky until reset.
  - err_addr_o captures the address of the first illegal access and then holds.
  - If both ports are illegal in the same cycle, the data port address is captured.
- Data port read address is sampled whether or not mem_we_i is high. A store therefore also produces a read result (old data) after READ_LATENCY.

Optional Feature:
RV_MEM_STATS_EN:
- Defined: adds output ports fetch_cnt_o[31:0], load_cnt_o[31:0] and store_cnt_o[31:0].
  - All three reset to 0.
  - In SERVE they count legal fetches, legal data-port cycles with mem_we_i=0, and legal writes, respectively.
  - Counters saturate at 32'hFFFF_FFFF.
  - No counting in CLEAR.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset, release, hold all inputs 0 -> busy_o=1 for exactly 256 cycles, then 0. Reading words 0..255 returns 32'h0 on both ports.
2. In SERVE, write 32'hDEADBEEF to byte addr 0x10, then fetch 0x10 next cycle (READ_LATENCY=1) -> instr_data_o=32'hDEADBEEF one cycle later, mem_data_o same via data port.
3. Same-cycle write 32'h12345678 to 0x20 and data read of 0x20 -> returns old value 0. Read on the following cycle returns 32'h12345678.
4. Fetch 0x402 (misaligned), then 0x800 (out of range) -> instr_data_o=32'h00000013 both times. err_o=1 after first edge, err_addr_o=32'h00000402 and unchanged after second.
5. Write to 0x400 (out of range, DEPTH=256) -> array unchanged, err_o=1. Then pull rst_i low mid-stream -> outputs 0 immediately, busy_o=1, err_o=0, CLEAR restarts.
6. READ_LATENCY=3, sweep fetch addresses 0,4,8,12 on consecutive cycles -> corresponding words appear on consecutive cycles starting 3 cycles after the first address. With RV_MEM_STATS_EN defined, fetch_cnt_o=4.

Source files
------------

// File: rtl/rv32_mem_responder.sv
// rv32_mem_responder
//   Memory-side responder for the RV32 core's instruction and data ports.
//   One word-organised storage array serves instruction fetches, data loads
//   and data stores. After reset the array is cleared word by word (busy_o high),
//   then requests are served with a fixed read latency. Illegal accesses are
//   flagged in a sticky error register that holds the first offending address.
//
// Parameters
//   DEPTH_WORDS  : number of 32-bit words (power of two, 16..65536)
//   READ_LATENCY : cycles from address sample to read data (1..4)
//   NOP_WORD     : instruction returned for an illegal fetch
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous reset, active low
//   instr_addr_i : fetch byte address, sampled every cycle
//   instr_data_o : fetched instruction, READ_LATENCY cycles later
//   mem_we_i     : data write strobe
//   mem_addr_i   : data byte address, sampled every cycle (also during stores)
//   mem_data_i   : store data
//   mem_data_o   : load data, READ_LATENCY cycles later
//   busy_o       : high while the post-reset clear runs
//   err_o        : sticky illegal-access flag
//   err_addr_o   : byte address of the first illegal access since reset
//
// Optional build macro RV_MEM_STATS_EN adds saturating counters:
//   fetch_cnt_o  : legal fetches in SERVE
//   load_cnt_o   : legal data-port cycles with mem_we_i low
//   store_cnt_o  : legal writes
module rv32_mem_responder #(
  parameter int          DEPTH_WORDS  = 256,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_data_o,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
`ifdef RV_MEM_STATS_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] load_cnt_o,
  output logic [31:0] store_cnt_o
`endif
);

  localparam int             AW      = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]  LAST_IX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_next;

  logic          w_serve;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_idx;
  logic [31:0]   w_wr_data;

  logic [31:0]   r_mem [DEPTH_WORDS];

  // A byte address is legal when word aligned and inside the array; the
  // upper-bits test is the same as addr < 4*DEPTH_WORDS for a power-of-two depth.
  logic          w_i_legal;
  logic          w_d_legal;
  logic [AW-1:0] w_i_idx;
  logic [AW-1:0] w_d_idx;

  assign w_i_legal = (instr_addr_i[1:0] == 2'b00) && (instr_addr_i[31:AW+2] == '0);
  assign w_d_legal = (mem_addr_i[1:0] == 2'b00) && (mem_addr_i[31:AW+2] == '0);
  assign w_i_idx   = instr_addr_i[AW+1:2];
  assign w_d_idx   = mem_addr_i[AW+1:2];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // The single array write port is shared: the clear sweep owns it in CLEAR,
  // the data port owns it in SERVE.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_serve      = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_idx     = r_ptr;
    w_wr_data    = '0;
    case (r_state)
      ST_CLEAR: begin
        w_wr_en    = 1'b1;
        w_ptr_next = r_ptr + AW'(1);
        if (r_ptr == LAST_IX) begin
          w_state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        w_serve   = 1'b1;
        w_wr_en   = mem_we_i && w_d_legal;
        w_wr_idx  = w_d_idx;
        w_wr_data = mem_data_i;
      end
    endcase
  end

  assign busy_o = (r_state == ST_CLEAR);

  // ---------------------------------------------------------------- array
  // No reset on the storage so it maps onto block RAM; reads below are taken
  // before this edge's write lands, giving old data on a same-word collision.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  logic [31:0] w_i_stage;
  logic [31:0] w_d_stage;

  assign w_i_stage = !w_serve ? 32'h0 : (w_i_legal ? r_mem[w_i_idx] : NOP_WORD);
  assign w_d_stage = (w_serve && w_d_legal) ? r_mem[w_d_idx] : 32'h0;

  // ---------------------------------------------------------------- read pipes
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
    logic [31:0] r_i_q;
    logic [31:0] r_d_q;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          r_i_q <= '0;
          r_d_q <= '0;
        end else begin
          r_i_q <= w_i_stage;
          r_d_q <= w_d_stage;
        end
      end
    end else begin : g_next
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          r_i_q <= '0;
          r_d_q <= '0;
        end else begin
          r_i_q <= g_stage[gi-1].r_i_q;
          r_d_q <= g_stage[gi-1].r_d_q;
        end
      end
    end
  end

  assign instr_data_o = g_stage[READ_LATENCY-1].r_i_q;
  assign mem_data_o   = g_stage[READ_LATENCY-1].r_d_q;

  // ---------------------------------------------------------------- errors
  logic        r_err;
  logic [31:0] r_err_addr;

  // Only the first illegal access is captured; the data port wins a tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_serve && !r_err && (!w_i_legal || !w_d_legal)) begin
      r_err      <= 1'b1;
      r_err_addr <= !w_d_legal ? mem_addr_i : instr_addr_i;
    end
  end

  assign err_o      = r_err;
  assign err_addr_o = r_err_addr;

`ifdef RV_MEM_STATS_EN
  // ---------------------------------------------------------------- stats
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_load_cnt;
  logic [31:0] r_store_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetch_cnt <= '0;
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
    end else if (w_serve) begin
      if (w_i_legal && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_d_legal && !mem_we_i && (r_load_cnt != 32'hFFFF_FFFF)) begin
        r_load_cnt <= r_load_cnt + 32'd1;
      end
      if (w_d_legal && mem_we_i && (r_store_cnt != 32'hFFFF_FFFF)) begin
        r_store_cnt <= r_store_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign load_cnt_o  = r_load_cnt;
  assign store_cnt_o = r_store_cnt;
`endif

endmodule

// File: tb/tb_rv32_mem_responder.sv
// Testbench for rv32_mem_responder: directed vector table, hand-written
// reset / error-capture sequences, then randomized traffic checked against a
// word-array reference model with a latency queue.
module tb_rv32_mem_responder;

  localparam int          DEPTH = 256;
  localparam int          LAT   = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ia;
  logic        we;
  logic [31:0] ma;
  logic [31:0] md;
  logic [31:0] idata;
  logic [31:0] ddata;
  logic        busy;
  logic        err;
  logic [31:0] eaddr;
`ifdef RV_MEM_STATS_EN
  logic [31:0] fcnt;
  logic [31:0] lcnt;
  logic [31:0] scnt;
`endif

  always #5 clk = ~clk;

  rv32_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .READ_LATENCY(LAT),
    .NOP_WORD    (NOP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .instr_addr_i(ia),
    .instr_data_o(idata),
    .mem_we_i    (we),
    .mem_addr_i  (ma),
    .mem_data_i  (md),
    .mem_data_o  (ddata),
    .busy_o      (busy),
    .err_o       (err),
    .err_addr_o  (eaddr)
`ifdef RV_MEM_STATS_EN
    ,
    .fetch_cnt_o (fcnt),
    .load_cnt_o  (lcnt),
    .store_cnt_o (scnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // reference model
  logic [31:0] m_mem [DEPTH];
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];
  int          m_cyc;
  bit          m_err;
  logic [31:0] m_eaddr;
  int          m_f;
  int          m_l;
  int          m_s;

  typedef struct {
    logic [31:0] a_i;
    bit          w;
    logic [31:0] a_d;
    logic [31:0] d;
    logic [31:0] xi;
    logic [31:0] xd;
  } vec_t;

  vec_t tbl [16];

  function automatic bit legal(input logic [31:0] a);
    return ((a % 4) == 0) && (a < 4 * DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_i.delete();
    q_d.delete();
    for (int k = 0; k < LAT; k++) begin
      q_i.push_back(32'h0);
      q_d.push_back(32'h0);
    end
    // The clear sweep leaves every word zero before the first serve cycle.
    for (int k = 0; k < DEPTH; k++) m_mem[k] = 32'h0;
    m_cyc   = 0;
    m_err   = 1'b0;
    m_eaddr = 32'h0;
    m_f     = 0;
    m_l     = 0;
    m_s     = 0;
  endtask

  // One clock cycle of traffic. When use_x is set the read results expected
  // for this request come from the caller instead of the model.
  task automatic cycle(input logic [31:0] a_i, input bit w, input logic [31:0] a_d,
                       input logic [31:0] d, input bit use_x,
                       input logic [31:0] xi, input logic [31:0] xd);
    bit          serve;
    logic [31:0] ei;
    logic [31:0] ed;
    ia = a_i;
    we = w;
    ma = a_d;
    md = d;
    serve = (m_cyc >= DEPTH);
    ei = 32'h0;
    ed = 32'h0;
    if (serve) begin
      ei = legal(a_i) ? m_mem[a_i >> 2] : NOP;
      ed = legal(a_d) ? m_mem[a_d >> 2] : 32'h0;
    end
    if (use_x) begin
      ei = xi;
      ed = xd;
    end
    q_i.push_back(ei);
    q_d.push_back(ed);
    @(posedge clk);
    #1;
    void'(q_i.pop_front());
    void'(q_d.pop_front());
    if (serve) begin
      if (w && legal(a_d)) m_mem[a_d >> 2] = d;
      if (!m_err && (!legal(a_i) || !legal(a_d))) begin
        m_err   = 1'b1;
        m_eaddr = legal(a_d) ? a_i : a_d;
      end
      if (legal(a_i)) m_f++;
      if (legal(a_d) && !w) m_l++;
      if (legal(a_d) && w) m_s++;
    end
    m_cyc++;
    chk("instr_data", idata, q_i[0]);
    chk("mem_data", ddata, q_d[0]);
    chk("busy", {31'b0, busy}, {31'b0, (m_cyc < DEPTH)});
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("err_addr", eaddr, m_eaddr);
    if (serve) begin
      txn++;
      $display("txn %0d ia=%h we=%0d ma=%h md=%h -> idata=%h ddata=%h err=%0d eaddr=%h",
               txn, a_i, w, a_d, d, idata, ddata, err, eaddr);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_instr_data", idata, 32'h0);
    chk("rst_mem_data", ddata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_err_addr", eaddr, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_clear();
    for (int k = 0; k < DEPTH; k++) cycle(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    ia = 0; we = 0; ma = 0; md = 0;

    tbl[0]  = '{32'h000, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        32'h0};
    tbl[1]  = '{32'h010, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2]  = '{32'h010, 1'b1, 32'h020, 32'h12345678, 32'hDEADBEEF, 32'h0};
    tbl[3]  = '{32'h020, 1'b0, 32'h020, 32'h0,        32'h12345678, 32'h12345678};
    tbl[4]  = '{32'h000, 1'b1, 32'h000, 32'h00000A0A, 32'h0,        32'h0};
    tbl[5]  = '{32'h004, 1'b1, 32'h004, 32'h00004444, 32'h0,        32'h0};
    tbl[6]  = '{32'h008, 1'b1, 32'h008, 32'h00008888, 32'h0,        32'h0};
    tbl[7]  = '{32'h00C, 1'b1, 32'h00C, 32'h0000CCCC, 32'h0,        32'h0};
    tbl[8]  = '{32'h000, 1'b0, 32'h01C, 32'h0,        32'h00000A0A, 32'h0};
    tbl[9]  = '{32'h004, 1'b0, 32'h01C, 32'h0,        32'h00004444, 32'h0};
    tbl[10] = '{32'h008, 1'b0, 32'h01C, 32'h0,        32'h00008888, 32'h0};
    tbl[11] = '{32'h00C, 1'b0, 32'h01C, 32'h0,        32'h0000CCCC, 32'h0};
    tbl[12] = '{32'h402, 1'b0, 32'h010, 32'h0,        NOP,          32'hDEADBEEF};
    tbl[13] = '{32'h800, 1'b0, 32'h010, 32'h0,        NOP,          32'hDEADBEEF};
    tbl[14] = '{32'h020, 1'b1, 32'h400, 32'hFFFFFFFF, 32'h12345678, 32'h0};
    tbl[15] = '{32'h000, 1'b0, 32'h000, 32'h0,        32'h00000A0A, 32'h00000A0A};

    // power-on reset, clear sweep, then every word reads back zero
    apply_reset();
    run_clear();
    for (int k = 0; k < DEPTH; k++)
      cycle(32'(k * 4), 1'b0, 32'((DEPTH - 1 - k) * 4), 32'h0, 1'b0, 32'h0, 32'h0);

    // directed table: write/fetch, read-during-write, latency sweep, illegal accesses
    for (int k = 0; k < 16; k++)
      cycle(tbl[k].a_i, tbl[k].w, tbl[k].a_d, tbl[k].d, 1'b1, tbl[k].xi, tbl[k].xd);
    // drain so the last table results are observed
    for (int k = 0; k < LAT; k++) cycle(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    // reset in the middle of traffic restarts the clear
    cycle(32'h010, 1'b1, 32'h014, 32'h5555AAAA, 1'b0, 32'h0, 32'h0);
    apply_reset();
    run_clear();

    // random legal traffic, frequently hitting the same few words
    for (int k = 0; k < 300; k++) begin
      logic [31:0] ai;
      logic [31:0] ad;
      if ($urandom_range(0, 1) == 0) begin
        ai = 32'($urandom_range(0, 15)) << 2;
        ad = 32'($urandom_range(0, 15)) << 2;
      end else begin
        ai = 32'($urandom_range(0, DEPTH - 1)) << 2;
        ad = 32'($urandom_range(0, DEPTH - 1)) << 2;
      end
      cycle(ai, 1'($urandom_range(0, 1)), ad, $urandom, 1'b0, 32'h0, 32'h0);
    end

    // both ports illegal in one cycle: data address is captured
    cycle(32'h005, 1'b1, 32'h800, 32'h77777777, 1'b1, NOP, 32'h0);
    chk("tie_err_addr", eaddr, 32'h00000800);

    // random traffic including illegal addresses; capture must hold
    for (int k = 0; k < 200; k++) begin
      logic [31:0] ai;
      logic [31:0] ad;
      ai = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 15)) << 2);
      ad = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 15)) << 2);
      cycle(ai, 1'($urandom_range(0, 1)), ad, $urandom, 1'b0, 32'h0, 32'h0);
    end

`ifdef RV_MEM_STATS_EN
    chk("fetch_cnt", fcnt, 32'(m_f));
    chk("load_cnt", lcnt, 32'(m_l));
    chk("store_cnt", scnt, 32'(m_s));
`endif
    $display("model counts fetch=%0d load=%0d store=%0d", m_f, m_l, m_s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
